nibble_alu_sequencer: RTL and testbench



---
 rtl/nibble_alu_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_nibble_alu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_alu_sequencer.sv
// ----------------------------------------------------------------------------
// nibble_alu_sequencer
//
// Multi-cycle 8-bit ADD / SUB / NEG / PASS controller that time-shares one
// external 4-bit carry-lookahead adder slice. Every operation makes two adder
// passes: low nibble first, then high nibble, with the inter-nibble carry held
// in a register between them. The block owns the start/busy/done handshake,
// operand conditioning (one's complement plus carry-in for SUB and NEG),
// result assembly and the status flags.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  request pulse, sampled only while idle
//   op        in   2  00 ADD a+b, 01 SUB a-b, 10 NEG -a, 11 PASS a
//   a, b      in   8  operands, latched on an accepted start
//   busy      out  1  high from the cycle after acceptance until done falls
//   done      out  1  one-cycle pulse; result and flags valid from here on
//   result    out  8  registered result, held until the next done
//   carry     out  1  high-nibble carry-out (SUB/NEG: 1 = no borrow)
//   overflow  out  1  two's-complement signed overflow
//   zero      out  1  result == 0
//   add_a     out  4  shared adder operand A
//   add_b     out  4  shared adder operand B
//   add_cin   out  1  shared adder carry-in
//   add_sum   in   4  shared adder sum (combinational, same cycle)
//   add_cout  in   1  shared adder carry-out
//
// Timing: accept at edge E0, LO after E0, HI after E1, DONE after E2, idle
// again after E3. One operation per four cycles.
// ----------------------------------------------------------------------------
module nibble_alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carry,
    output logic       overflow,
    output logic       zero,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [3:0] add_sum,
    input  logic       add_cout
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_NEG  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e     state_q;
    state_e     state_d;

    op_e        op_sel;

    // Effective operands and carry-in, conditioned from the raw inputs.
    logic [7:0] x_d;
    logic [7:0] y_d;
    logic       c0_d;

    // Latched effective operands; raw inputs are free to change after accept.
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic       c0_q;

    // Low-nibble partial result and the carry handed to the high pass.
    logic [3:0] res_lo_q;
    logic       cy_q;

    logic       accept;
    logic [7:0] sum_full;

    assign op_sel   = op_e'(op);
    assign accept   = (state_q == S_IDLE) && start;
    assign sum_full = {add_sum, res_lo_q};

    // ------------------------------------------------------------------------
    // Operand conditioning. Subtraction is x + ~y + 1; negation is 0 + ~a + 1.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        x_d  = a;
        y_d  = b;
        c0_d = 1'b0;
        case (op_sel)
            OP_ADD: begin
                x_d  = a;
                y_d  = b;
                c0_d = 1'b0;
            end
            OP_SUB: begin
                x_d  = a;
                y_d  = ~b;
                c0_d = 1'b1;
            end
            OP_NEG: begin
                x_d  = 8'h00;
                y_d  = ~a;
                c0_d = 1'b1;
            end
            OP_PASS: begin
                x_d  = a;
                y_d  = 8'h00;
                c0_d = 1'b0;
            end
            default: begin
                x_d  = a;
                y_d  = b;
                c0_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic and adder drive. The adder ports decode straight from
    // state and latched operands so the adder sees them a full cycle ahead of
    // the capturing edge; they are zero whenever no pass is in progress.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                add_a   = x_q[3:0];
                add_b   = y_q[3:0];
                add_cin = c0_q;
                state_d = S_HI;
            end
            S_HI: begin
                add_a   = x_q[7:4];
                add_b   = y_q[7:4];
                add_cin = cy_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and handshake outputs. busy and done are registered from
    // the next state so they come out of flops rather than decode.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch, low-nibble capture, result and flag capture.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and partial-result registers are reset along
            // with the outputs so the adder ports stay at a known value and a
            // reset mid-operation leaves nothing stale behind.
            x_q      <= 8'h00;
            y_q      <= 8'h00;
            c0_q     <= 1'b0;
            res_lo_q <= 4'h0;
            cy_q     <= 1'b0;
            result   <= 8'h00;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            if (accept) begin
                x_q  <= x_d;
                y_q  <= y_d;
                c0_q <= c0_d;
            end

            if (state_q == S_LO) begin
                res_lo_q <= add_sum;
                cy_q     <= add_cout;
            end

            if (state_q == S_HI) begin
                result   <= sum_full;
                carry    <= add_cout;
                // Signed overflow: like-signed effective operands producing a
                // sum of the opposite sign.
                overflow <= (x_q[7] == y_q[7]) && (add_sum[3] != x_q[7]);
                zero     <= (sum_full == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_nibble_alu_sequencer
//
// Bench for nibble_alu_sequencer. Models the external 4-bit adder slice as a
// combinational sum, then applies a table of hand-computed vectors, a batch
// of random operations checked against a plain-arithmetic reference model,
// a continuous-start sequence and a reset in the middle of an operation.
// ----------------------------------------------------------------------------
module tb_nibble_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cy;
        logic       ov;
        logic       z;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       c0;
    } eff_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    // External adder slice.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_alu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: the operation's meaning in ordinary integer arithmetic.
    function automatic vec_t ref_model(input logic [1:0] o, input logic [7:0] ai, input logic [7:0] bi);
        vec_t r;
        int   sa;
        int   sb;
        int   s;
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        r.op = o;
        r.a  = ai;
        r.b  = bi;
        case (o)
            2'b00: begin
                r.res = 8'(ai + bi);
                r.cy  = (int'(ai) + int'(bi)) > 255;
                s     = sa + sb;
            end
            2'b01: begin
                r.res = 8'(ai - bi);
                r.cy  = (ai >= bi);
                s     = sa - sb;
            end
            2'b10: begin
                r.res = 8'(-ai);
                r.cy  = (ai == 8'h00);
                s     = -sa;
            end
            default: begin
                r.res = ai;
                r.cy  = 1'b0;
                s     = sa;
            end
        endcase
        r.ov = (s > 127) || (s < -128);
        r.z  = (r.res == 8'h00);
        return r;
    endfunction

    // Effective adder operands as presented to the adder slice.
    function automatic eff_t eff(input logic [1:0] o, input logic [7:0] ai, input logic [7:0] bi);
        eff_t f;
        case (o)
            2'b00:   begin f.x = ai;    f.y = bi;    f.c0 = 1'b0; end
            2'b01:   begin f.x = ai;    f.y = ~bi;   f.c0 = 1'b1; end
            2'b10:   begin f.x = 8'h00; f.y = ~ai;   f.c0 = 1'b1; end
            default: begin f.x = ai;    f.y = 8'h00; f.c0 = 1'b0; end
        endcase
        return f;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s/busy", tag), busy, 0);
        check($sformatf("%s/done", tag), done, 0);
        check($sformatf("%s/result", tag), result, 0);
        check($sformatf("%s/flags", tag), {carry, overflow, zero}, 0);
        check($sformatf("%s/adder", tag), {add_a, add_b, add_cin}, 0);
    endtask

    // One full operation from idle, with operand scrambling during busy.
    // Called at a falling edge with the DUT idle; returns at the falling edge
    // of the idle cycle following done.
    task automatic do_op(input vec_t e, input string tag);
        eff_t f;
        logic lo_c;
        f    = eff(e.op, e.a, e.b);
        lo_c = (5'(f.x[3:0]) + 5'(f.y[3:0]) + 5'(f.c0)) > 5'd15;

        @(negedge clk);
        check($sformatf("%s/idle_adder", tag), {add_a, add_b, add_cin}, 0);
        start = 1'b1;
        op    = e.op;
        a     = e.a;
        b     = e.b;

        @(negedge clk);  // LO
        check($sformatf("%s/lo_busy", tag), {busy, done}, 2'b10);
        check($sformatf("%s/lo_adder", tag), {add_a, add_b, add_cin}, {f.x[3:0], f.y[3:0], f.c0});
        start = 1'($urandom);
        op    = 2'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);

        @(negedge clk);  // HI
        check($sformatf("%s/hi_busy", tag), {busy, done}, 2'b10);
        check($sformatf("%s/hi_adder", tag), {add_a, add_b, add_cin}, {f.x[7:4], f.y[7:4], lo_c});
        start = 1'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);

        @(negedge clk);  // DONE
        start = 1'b0;
        check($sformatf("%s/done_busy", tag), {busy, done}, 2'b11);
        check($sformatf("%s/result", tag), result, e.res);
        check($sformatf("%s/carry", tag), carry, e.cy);
        check($sformatf("%s/overflow", tag), overflow, e.ov);
        check($sformatf("%s/zero", tag), zero, e.z);
        check($sformatf("%s/done_adder", tag), {add_a, add_b, add_cin}, 0);

        @(negedge clk);  // IDLE
        check($sformatf("%s/idle_busy", tag), {busy, done}, 2'b00);
        check($sformatf("%s/held", tag), result, e.res);
    endtask

    logic [7:0] av [24];
    logic [7:0] bv [24];

    initial begin
        vec_t e;

        //        op     a      b      res    cy    ov    z
        tbl[0] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 8'h00, 8'h5C, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{2'b10, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{2'b11, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{2'b01, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{2'b11, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};

        // Reset state.
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i], $sformatf("tbl%0d", i));
        end

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            e = ref_model(2'($urandom), 8'($urandom), 8'($urandom));
            do_op(e, $sformatf("rnd%0d", i));
        end

        // start held high continuously with op=ADD at every acceptance:
        // accepts at t=0,4,8..., done seen at t=3,7,11...
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        av[0] = 8'($urandom);
        bv[0] = 8'($urandom);
        a     = av[0];
        b     = bv[0];
        for (int t = 1; t < 24; t++) begin
            @(negedge clk);
            check($sformatf("hold%0d/done", t), done, (t % 4) == 3);
            check($sformatf("hold%0d/busy", t), busy, (t % 4) != 0);
            if ((t % 4) == 3) begin
                e = ref_model(2'b00, av[t-3], bv[t-3]);
                check($sformatf("hold%0d/result", t), result, e.res);
                check($sformatf("hold%0d/flags", t), {carry, overflow, zero}, {e.cy, e.ov, e.z});
            end
            av[t] = 8'($urandom);
            bv[t] = 8'($urandom);
            a     = av[t];
            b     = bv[t];
            op    = ((t % 4) == 0) ? 2'b00 : 2'($urandom);
        end
        start = 1'b0;
        @(negedge clk);
        check("hold_end/busy", {busy, done}, 2'b00);

        // Reset during HI: everything clears at once, no done follows.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 8'hF7;
        b     = 8'h19;
        @(negedge clk);  // LO
        start = 1'b0;
        @(negedge clk);  // HI
        check("pre_rst/hi_busy", {busy, done}, 2'b10);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        @(negedge clk);
        check("mid_rst/hold_done", done, 0);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d/busy_done", t), {busy, done}, 2'b00);
        end
        do_op(tbl[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
